sr_latch_sequencer: RTL and testbench
=====================================

SR_LATCH_SEQUENCER -- requirements
Module: sr_latch_sequencer

Interface
REQ-001 SHALL have parameter PULSE_W, default 4: cycles S or R is driven high per operation (legal 1..255).
REQ-002 SHALL have parameter SETTLE_W, default 3: cycles both drives held low before q is checked (legal 2..255).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_a_valid  input  1  requester A has an operation pending.
REQ-006 SHALL have port req_a_op  input  1  requester A operation: 1 = set, 0 = reset.
REQ-007 SHALL have port req_a_ready  output  1  requester A operation is accepted this cycle if valid.
REQ-008 SHALL have ports req_b_valid, req_b_op (inputs, 1 bit each) and req_b_ready (output, 1 bit), identical in meaning to the A ports.
REQ-009 SHALL have port s_out  output  1  registered drive to the latch set input.
REQ-010 SHALL have port r_out  output  1  registered drive to the latch reset input.
REQ-011 SHALL have port q_in  input  1  latch q, asynchronous to clk.
REQ-012 SHALL have port qb_in  input  1  latch qb, asynchronous to clk.
REQ-013 SHALL have port fault_clr  input  1  single-cycle clear of fault and err_cnt.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at the end of each operation.
REQ-016 SHALL have port last_q  output  1  synchronized q captured by the most recent check.
REQ-017 SHALL have port fault  output  1  sticky flag set by any failed check.
REQ-018 SHALL have port err_cnt  output  8  count of failed checks, saturating.

Function
REQ-019 SHALL pass q_in and qb_in through separate two-flop synchronizers; every check SHALL use the synchronized values.
REQ-020 SHALL implement the states IDLE, PULSE, SETTLE and DONE.
REQ-021 SHALL drive req_x_ready high only in IDLE, and only for the requester that is granted in that cycle; both ready signals SHALL be low in all other states.
REQ-022 SHALL arbitrate round-robin: a single valid requester is granted; when both are valid, the requester not granted last wins; after reset A has priority.
REQ-023 SHALL accept an operation on the edge where ready and valid are both high, latch its op and requester, and move IDLE -> PULSE.
REQ-024 SHALL, in PULSE, hold s_out high (op = 1) or r_out high (op = 0) for exactly PULSE_W cycles, starting the cycle after acceptance, then move to SETTLE.
REQ-025 SHALL never assert s_out and r_out in the same cycle.
REQ-026 SHALL, in SETTLE, hold both drives low for exactly SETTLE_W cycles and sample the synchronized q and qb at the final SETTLE edge.
REQ-027 SHALL treat a check as passing when q = op and qb = !op; q = qb, or any other mismatch, SHALL be a failure.
REQ-028 SHALL, in DONE, hold done high for one cycle with last_q, fault and err_cnt already updated, then return to IDLE.
REQ-029 SHALL on each failure set fault and increment err_cnt, saturating at 255 with no wrap.
REQ-030 SHALL have fault_clr zero fault and err_cnt; if fault_clr coincides with a failure, the failure SHALL win, leaving fault = 1 and err_cnt = 1.
REQ-031 SHALL keep the operation from acceptance to return to IDLE at PULSE_W + SETTLE_W + 1 cycles; the earliest next acceptance SHALL be the first IDLE cycle.
REQ-032 SHALL ignore valid and op changes while busy, with no queuing.

Reset
REQ-033 SHALL, on a clk edge with rst high, force IDLE, s_out = r_out = 0, busy = done = 0, last_q = 0, fault = 0, err_cnt = 0, clear both synchronizers, and restore A priority.
REQ-034 SHALL have rst asserted mid-PULSE drop the active drive low in the next cycle, with no check and no done.

Verification
REQ-035 SHALL cover, with PULSE_W = 4 and SETTLE_W = 3: A set accepted at cycle 0 with the latch model correct -> s_out high for cycles 1-4, done in cycle 8, last_q = 1, fault = 0.
REQ-036 SHALL cover A and B both valid from IDLE after reset -> A granted first, B granted on the next IDLE cycle, A granted third if both are still valid.
REQ-037 SHALL cover a latch model stuck at q = qb = 0 with 3 set operations -> fault = 1 and err_cnt = 3; then fault_clr -> both 0.
REQ-038 SHALL cover 300 consecutive failures -> err_cnt holds at 255.
REQ-039 SHALL cover rst asserted in cycle 2 of PULSE -> r_out low in the next cycle, no done, ready high again in IDLE.
REQ-040 SHALL cover fault_clr asserted in the same cycle as a failing check -> fault = 1 and err_cnt = 1; a checker SHALL confirm that s_out and r_out are never both high.

Source files
------------

// File: rtl/sr_latch_sequencer_if.sv
// Request bus for the SR latch sequencer: two requesters, each with valid/op/ready.
// Latency: none, this is wiring only.
// Backpressure: ready comes from the sequencer and is high only for the requester granted that cycle.
interface sr_latch_sequencer_if;
   logic req_a_valid;
   logic req_a_op;
   logic req_a_ready;
   logic req_b_valid;
   logic req_b_op;
   logic req_b_ready;

   // Requester side: drives operations, observes ready.
   modport master (
      output req_a_valid, req_a_op, req_b_valid, req_b_op,
      input  req_a_ready, req_b_ready
   );

   // Sequencer side: observes operations, returns ready.
   modport slave (
      input  req_a_valid, req_a_op, req_b_valid, req_b_op,
      output req_a_ready, req_b_ready
   );
endinterface

// File: rtl/sr_latch_sequencer.sv
// Pulses an external SR latch for set/reset operations from two round-robin requesters and checks q afterwards.
// Latency: PULSE_W + SETTLE_W + 1 cycles from acceptance to the return to IDLE; done is high in the last of them.
// Backpressure: one operation at a time; ready is low while busy and requests are neither queued nor remembered.
module sr_latch_sequencer #(
   parameter int PULSE_W  = 4,
   parameter int SETTLE_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   sr_latch_sequencer_if.slave   req,
   output logic                  s_out,
   output logic                  r_out,
   input  logic                  q_in,
   input  logic                  qb_in,
   input  logic                  fault_clr,
   output logic                  busy,
   output logic                  done,
   output logic                  last_q,
   output logic                  fault,
   output logic [7:0]            err_cnt
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_PULSE  = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Counters run down to zero, so they are loaded with the cycle count minus one.
   localparam logic [7:0] PULSE_LAST  = 8'(PULSE_W - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_W - 1);

   logic [1:0] r_state;
   logic [7:0] r_cnt;
   logic       r_op;
   logic       r_last_b;     // 1 when B was granted most recently; reset to 1 so A wins the first tie
   logic       r_s;
   logic       r_r;
   logic       r_q_meta;
   logic       r_q_sync;
   logic       r_qb_meta;
   logic       r_qb_sync;
   logic       r_last_q;
   logic       r_fault;
   logic [7:0] r_err_cnt;

   logic w_idle;
   logic w_grant_a;
   logic w_grant_b;
   logic w_accept;
   logic w_accept_op;
   logic w_check_now;
   logic w_check_pass;

   assign w_idle    = (r_state == ST_IDLE);
   assign w_grant_a = w_idle & req.req_a_valid & (~req.req_b_valid | r_last_b);
   assign w_grant_b = w_idle & req.req_b_valid & (~req.req_a_valid | ~r_last_b);
   assign w_accept  = w_grant_a | w_grant_b;
   assign w_accept_op = w_grant_a ? req.req_a_op : req.req_b_op;

   // The check fires on the last SETTLE edge. A latch that reads q == qb fails either way.
   assign w_check_now  = (r_state == ST_SETTLE) && (r_cnt == 8'd0);
   assign w_check_pass = (r_q_sync == r_op) && (r_qb_sync == ~r_op);

   assign req.req_a_ready = w_grant_a;
   assign req.req_b_ready = w_grant_b;

   assign s_out   = r_s;
   assign r_out   = r_r;
   assign busy    = ~w_idle;
   assign done    = (r_state == ST_DONE);
   assign last_q  = r_last_q;
   assign fault   = r_fault;
   assign err_cnt = r_err_cnt;

   // Two-flop synchronizers for the latch outputs, which are asynchronous to clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q_meta  <= 1'b0;
         r_q_sync  <= 1'b0;
         r_qb_meta <= 1'b0;
         r_qb_sync <= 1'b0;
      end else begin
         r_q_meta  <= q_in;
         r_q_sync  <= r_q_meta;
         r_qb_meta <= qb_in;
         r_qb_sync <= r_qb_meta;
      end
   end

   // Operation sequencing: accept, drive the pulse, settle, then flag done for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 8'd0;
         r_op     <= 1'b0;
         r_last_b <= 1'b1;
         r_s      <= 1'b0;
         r_r      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state  <= ST_PULSE;
                  r_cnt    <= PULSE_LAST;
                  r_op     <= w_accept_op;
                  r_last_b <= w_grant_b;
                  r_s      <= w_accept_op;
                  r_r      <= ~w_accept_op;
               end
            end
            ST_PULSE: begin
               if (r_cnt == 8'd0) begin
                  r_state <= ST_SETTLE;
                  r_cnt   <= SETTLE_LAST;
                  r_s     <= 1'b0;
                  r_r     <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == 8'd0) begin
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Check results: capture q, and keep the sticky fault and the saturating error count.
   // A failure on the same edge as fault_clr takes priority and restarts the count at one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_q  <= 1'b0;
         r_fault   <= 1'b0;
         r_err_cnt <= 8'd0;
      end else begin
         if (w_check_now) begin
            r_last_q <= r_q_sync;
         end
         if (w_check_now && !w_check_pass) begin
            r_fault <= 1'b1;
            if (fault_clr) begin
               r_err_cnt <= 8'd1;
            end else if (r_err_cnt != 8'hFF) begin
               r_err_cnt <= r_err_cnt + 8'd1;
            end
         end else if (fault_clr) begin
            r_fault   <= 1'b0;
            r_err_cnt <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Bench for sr_latch_sequencer with a clocked SR latch model and a round-robin grant model.
// Latency: every operation is expected to take PW + SW + 1 cycles, with done in the last of them.
// Backpressure: while busy, the bench toggles valid and op at random and expects both readies to stay low.
module tb_sr_latch_sequencer;
   localparam int PW = 4;
   localparam int SW = 3;
   localparam int OPLEN = PW + SW + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_out, r_out, q_in, qb_in, fault_clr;
   logic       busy, done, last_q, fault;
   logic [7:0] err_cnt;

   int total = 0;
   int bad = 0;

   // Latch model: 0 = well-behaved SR latch, 1 = stuck with q = qb = 0.
   int   latch_mode = 0;
   logic m_q = 1'b0;

   sr_latch_sequencer_if ifc ();

   sr_latch_sequencer #(.PULSE_W(PW), .SETTLE_W(SW)) dut (
      .clk(clk), .rst(rst), .req(ifc),
      .s_out(s_out), .r_out(r_out), .q_in(q_in), .qb_in(qb_in),
      .fault_clr(fault_clr), .busy(busy), .done(done),
      .last_q(last_q), .fault(fault), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (s_out) m_q <= 1'b1;
      else if (r_out) m_q <= 1'b0;
   end
   assign q_in  = (latch_mode == 1) ? 1'b0 : m_q;
   assign qb_in = (latch_mode == 1) ? 1'b0 : ~m_q;

   always @(negedge clk) begin
      total++;
      if (s_out === 1'b1 && r_out === 1'b1) begin
         bad++;
         $display("FAIL overlap: s_out=%b r_out=%b both high at %0t", s_out, r_out, $time);
      end
   end

   task automatic idle_inputs();
      ifc.req_a_valid = 1'b0; ifc.req_a_op = 1'b0;
      ifc.req_b_valid = 1'b0; ifc.req_b_op = 1'b0;
      fault_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; idle_inputs();
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (busy === 1'b0) begin ok = 1'b1; return; end
         @(negedge clk);
      end
   endtask

   // Issues one operation from a single requester, so it is granted at once.
   // Returns at the negedge of the DONE cycle.
   task automatic run_op(input bit use_b, input bit op);
      if (use_b) begin ifc.req_b_valid = 1'b1; ifc.req_b_op = op; end
      else       begin ifc.req_a_valid = 1'b1; ifc.req_a_op = op; end
      @(negedge clk);
      ifc.req_a_valid = 1'b0; ifc.req_b_valid = 1'b0;
      repeat (OPLEN - 1) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; idle_inputs();
      do_reset();
      total++; if (s_out !== 1'b0)   begin bad++; $display("FAIL reset_s_out: got %b want 0", s_out); end
      total++; if (r_out !== 1'b0)   begin bad++; $display("FAIL reset_r_out: got %b want 0", r_out); end
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (last_q !== 1'b0)  begin bad++; $display("FAIL reset_last_q: got %b want 0", last_q); end
      total++; if (fault !== 1'b0)   begin bad++; $display("FAIL reset_fault: got %b want 0", fault); end
      total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      total++; if (ifc.req_a_ready !== 1'b0 || ifc.req_b_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready: got a=%b b=%b want 0 0", ifc.req_a_ready, ifc.req_b_ready);
      end
   endtask

   task automatic test_single_set();
      latch_mode = 0;
      ifc.req_a_valid = 1'b1; ifc.req_a_op = 1'b1;
      #1;
      total++; if (ifc.req_a_ready !== 1'b1 || ifc.req_b_ready !== 1'b0) begin
         bad++; $display("FAIL set_ready: got a=%b b=%b want 1 0", ifc.req_a_ready, ifc.req_b_ready);
      end
      @(negedge clk);
      ifc.req_a_valid = 1'b0;
      for (int c = 1; c <= OPLEN + 1; c++) begin
         total++; if (s_out !== (c <= PW)) begin bad++; $display("FAIL set_s_out c%0d: got %b want %b", c, s_out, c <= PW); end
         total++; if (r_out !== 1'b0) begin bad++; $display("FAIL set_r_out c%0d: got %b want 0", c, r_out); end
         total++; if (busy !== (c <= OPLEN)) begin bad++; $display("FAIL set_busy c%0d: got %b want %b", c, busy, c <= OPLEN); end
         total++; if (done !== (c == OPLEN)) begin bad++; $display("FAIL set_done c%0d: got %b want %b", c, done, c == OPLEN); end
         if (c == OPLEN) begin
            total++; if (last_q !== 1'b1) begin bad++; $display("FAIL set_last_q: got %b want 1", last_q); end
            total++; if (fault !== 1'b0)  begin bad++; $display("FAIL set_fault: got %b want 0", fault); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_arbitration();
      bit ok;
      do_reset();
      ifc.req_a_valid = 1'b1; ifc.req_a_op = 1'($urandom_range(0, 1));
      ifc.req_b_valid = 1'b1; ifc.req_b_op = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) begin
         wait_idle(ok);
         total++; if (!ok) begin bad++; $display("FAIL arb_timeout k%0d: busy=%b want 0", k, busy); end
         #1;
         total++; if (ifc.req_a_ready !== (k != 1) || ifc.req_b_ready !== (k == 1)) begin
            bad++; $display("FAIL arb_grant k%0d: got a=%b b=%b want %b %b", k,
                            ifc.req_a_ready, ifc.req_b_ready, k != 1, k == 1);
         end
         @(negedge clk);
      end
      idle_inputs();
      wait_idle(ok);
   endtask

   task automatic test_random();
      bit ok, av, bv, aop, bop, ga, gb, exp_op;
      bit exp_last_b;
      do_reset();
      latch_mode = 0;
      exp_last_b = 1'b1;
      for (int n = 0; n < 60; n++) begin
         wait_idle(ok);
         total++; if (!ok) begin bad++; $display("FAIL rand_timeout n%0d: busy=%b want 0", n, busy); end
         av = 1'($urandom_range(0, 1)); bv = 1'($urandom_range(0, 1));
         aop = 1'($urandom_range(0, 1)); bop = 1'($urandom_range(0, 1));
         ifc.req_a_valid = av; ifc.req_a_op = aop;
         ifc.req_b_valid = bv; ifc.req_b_op = bop;
         ga = av && (!bv || exp_last_b);
         gb = bv && (!av || !exp_last_b);
         #1;
         total++; if (ifc.req_a_ready !== ga || ifc.req_b_ready !== gb) begin
            bad++; $display("FAIL rand_grant n%0d: got a=%b b=%b want %b %b", n,
                            ifc.req_a_ready, ifc.req_b_ready, ga, gb);
         end
         @(negedge clk);
         if (ga || gb) begin
            exp_op = ga ? aop : bop;
            exp_last_b = gb;
            for (int c = 1; c <= OPLEN; c++) begin
               ifc.req_a_valid = 1'($urandom_range(0, 1)); ifc.req_a_op = 1'($urandom_range(0, 1));
               ifc.req_b_valid = 1'($urandom_range(0, 1)); ifc.req_b_op = 1'($urandom_range(0, 1));
               #1;
               total++; if (ifc.req_a_ready !== 1'b0 || ifc.req_b_ready !== 1'b0) begin
                  bad++; $display("FAIL rand_busy_ready n%0d c%0d: got a=%b b=%b want 0 0", n, c,
                                  ifc.req_a_ready, ifc.req_b_ready);
               end
               total++; if (s_out !== (c <= PW && exp_op) || r_out !== (c <= PW && !exp_op)) begin
                  bad++; $display("FAIL rand_drive n%0d c%0d: got s=%b r=%b want %b %b", n, c,
                                  s_out, r_out, c <= PW && exp_op, c <= PW && !exp_op);
               end
               if (c == OPLEN) begin
                  total++; if (done !== 1'b1 || last_q !== exp_op || fault !== 1'b0) begin
                     bad++; $display("FAIL rand_result n%0d: got done=%b q=%b fault=%b want 1 %b 0", n,
                                     done, last_q, fault, exp_op);
                  end
               end
               @(negedge clk);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_stuck();
      do_reset();
      latch_mode = 1;
      for (int k = 1; k <= 3; k++) begin
         run_op(1'b0, 1'b1);
         total++; if (fault !== 1'b1 || err_cnt !== 8'(k) || done !== 1'b1) begin
            bad++; $display("FAIL stuck_count k%0d: got fault=%b err=%0d done=%b want 1 %0d 1", k, fault, err_cnt, done, k);
         end
         @(negedge clk);
      end
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      total++; if (fault !== 1'b0 || err_cnt !== 8'd0) begin
         bad++; $display("FAIL stuck_clear: got fault=%b err=%0d want 0 0", fault, err_cnt);
      end
   endtask

   task automatic test_saturate();
      int exp_cnt;
      latch_mode = 1;
      for (int k = 1; k <= 300; k++) begin
         run_op(1'(k & 1), 1'(k & 1));
         exp_cnt = (k > 255) ? 255 : k;
         total++; if (err_cnt !== 8'(exp_cnt)) begin
            bad++; $display("FAIL saturate k%0d: got %0d want %0d", k, err_cnt, exp_cnt);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_pulse();
      bit seen_done, ok;
      do_reset();
      latch_mode = 0;
      ifc.req_a_valid = 1'b1; ifc.req_a_op = 1'b0;
      @(negedge clk);
      ifc.req_a_valid = 1'b0;
      total++; if (r_out !== 1'b1) begin bad++; $display("FAIL midrst_r_c1: got %b want 1", r_out); end
      @(negedge clk);
      total++; if (r_out !== 1'b1) begin bad++; $display("FAIL midrst_r_c2: got %b want 1", r_out); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (r_out !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL midrst_drop: got r=%b busy=%b want 0 0", r_out, busy);
      end
      seen_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) seen_done = 1'b1;
         @(negedge clk);
      end
      total++; if (seen_done || last_q !== 1'b0) begin
         bad++; $display("FAIL midrst_nodone: got done_seen=%b last_q=%b want 0 0", seen_done, last_q);
      end
      ifc.req_a_valid = 1'b1; ifc.req_a_op = 1'b1;
      #1;
      total++; if (ifc.req_a_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", ifc.req_a_ready); end
      @(negedge clk);
      ifc.req_a_valid = 1'b0;
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL midrst_timeout: busy=%b want 0", busy); end
   endtask

   task automatic test_clr_coincide();
      do_reset();
      latch_mode = 1;
      run_op(1'b0, 1'b1);
      @(negedge clk);
      ifc.req_a_valid = 1'b1; ifc.req_a_op = 1'b1;
      @(negedge clk);
      ifc.req_a_valid = 1'b0;
      repeat (OPLEN - 2) @(negedge clk);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      total++; if (done !== 1'b1 || fault !== 1'b1 || err_cnt !== 8'd1) begin
         bad++; $display("FAIL clr_coincide: got done=%b fault=%b err=%0d want 1 1 1", done, fault, err_cnt);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single_set();
      test_arbitration();
      test_random();
      test_stuck();
      test_saturate();
      test_reset_mid_pulse();
      test_clr_coincide();
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
